// File: rtl/riscv_uart_pkg.sv
// Shared definitions for the UART transmit path: data/offset widths,
// register offsets decoded upstream, and the transmit FSM state type.
package riscv_uart_pkg;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_ADDR_LOW_WIDTH = 12;

    localparam logic [UART_ADDR_LOW_WIDTH-1:0] A_RD = 12'h000;
    localparam logic [UART_ADDR_LOW_WIDTH-1:0] A_WR = 12'h004;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/riscv_uart_fifo.sv
// Small synchronous FIFO. Pointers wrap modulo DEPTH (a power of two);
// a separate occupancy counter keeps full and empty distinct at wrap.
// Push while full and pop while empty are ignored.
module riscv_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               wdata_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Storage array: written on accepted pushes only; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy counter; reset discards all queued entries.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/riscv_uart_tx.sv
// UART transmit engine, 8N1, LSB first. Bytes are queued in a small FIFO
// and serialised by a four-state FSM; a pending byte at the end of a stop
// bit starts the next frame with no idle gap.
module riscv_uart_tx
    import riscv_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [UART_DATA_WIDTH-1:0]          in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                txd,
    output logic                                tx_busy,
    output logic                                tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    // tx_done is registered, so it is armed one cycle before the last stop cycle.
    localparam logic [BW-1:0] BAUD_ARM  = BW'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("riscv_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
        $error("riscv_uart_tx: FIFO_DEPTH must be a power of two and >= 2");
    end

    uart_tx_state_t             state_q;
    logic [BW-1:0]              baud_q;
    logic [2:0]                 bit_q;
    logic [UART_DATA_WIDTH-1:0] shift_q;
    logic                       txd_q;
    logic                       done_q;

    logic                       push_s;
    logic                       pop_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic                       baud_last_s;
    logic [UART_DATA_WIDTH-1:0] fifo_rdata_s;
    logic [CW-1:0]              fifo_count_s;

    assign in_ready    = !fifo_full_s;
    assign push_s      = in_valid && in_ready;
    assign baud_last_s = (baud_q == BAUD_LAST);
    assign txd         = txd_q;
    assign tx_done     = done_q;
    assign fifo_count  = fifo_count_s;
    assign tx_busy     = (state_q != IDLE) || (fifo_count_s != {CW{1'b0}});

    riscv_uart_fifo #(
        .WIDTH (UART_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (in_data),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Pop decision: from IDLE whenever data waits, or at the last stop cycle.
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            IDLE:    pop_s = !fifo_empty_s;
            STOP:    pop_s = baud_last_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Frame FSM with baud/bit counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= {BW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= {UART_DATA_WIDTH{1'b0}};
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && (baud_q == BAUD_ARM);
            case (state_q)
                IDLE: begin
                    baud_q <= {BW{1'b0}};
                    bit_q  <= 3'd0;
                    if (!fifo_empty_s) begin
                        shift_q <= fifo_rdata_s;
                        txd_q   <= 1'b0;
                        state_q <= START;
                    end else begin
                        txd_q   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_last_s) begin
                        baud_q  <= {BW{1'b0}};
                        bit_q   <= 3'd0;
                        txd_q   <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q  <= baud_q + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        baud_q <= {BW{1'b0}};
                        if (bit_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            txd_q   <= shift_q[1];
                            shift_q <= {1'b0, shift_q[UART_DATA_WIDTH-1:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_last_s) begin
                        baud_q <= {BW{1'b0}};
                        if (!fifo_empty_s) begin
                            shift_q <= fifo_rdata_s;
                            txd_q   <= 1'b0;
                            state_q <= START;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    baud_q  <= {BW{1'b0}};
                    txd_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
